// File: rtl/phy_tx.sv
// -----------------------------------------------------------------------------
// phy_tx
//
// Two-lane byte serializer. Each lane takes one parallel byte every 8 clocks
// and shifts it out MSB first, with no gap between bytes. After reset, or after
// enable is raised again, both lanes send SYNC_COUNT COMMA bytes so the
// receiver can align. Only then does the block start accepting data.
//
// Parameters
//   COMMA       idle/alignment byte. It is sent on any lane that has no valid
//               data, and on both lanes during the alignment phase.
//   SYNC_COUNT  number of alignment commas sent before data is accepted (>= 1).
//
// Ports
//   clk_8f      bit clock. This is the only clock in the block.
//   reset       synchronous, active-high. It takes priority over enable.
//   enable      transmitter enable. When low it acts like reset on the same edge.
//   data_in_0   lane 0 byte. It is sampled only on load edges.
//   valid_in_0  lane 0 byte qualifier.
//   data_in_1   lane 1 byte. It is sampled only on load edges.
//   valid_in_1  lane 1 byte qualifier.
//   out_0       lane 0 serial bit (registered).
//   out_1       lane 1 serial bit (registered).
//   ready       high in the single cycle before each load edge while ACTIVE.
//   active      high while the state machine is in ACTIVE.
// -----------------------------------------------------------------------------
module phy_tx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    output logic       out_0,
    output logic       out_1,
    output logic       ready,
    output logic       active
);

    // The comma counter only needs to reach SYNC_COUNT-1. The final comma
    // causes the move to ACTIVE instead of a further increment.
    localparam int CW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
    localparam logic [CW-1:0] LAST_COMMA = CW'(SYNC_COUNT - 1);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_reg;
    logic [2:0]      bit_cnt_reg;
    logic [CW-1:0]   comma_cnt_reg;
    logic            ready_reg;
    logic            active_reg;

    // Reset and a dropped enable have the same effect. Keeping one qualifier
    // means every register clears on exactly the same edge.
    logic halt;
    assign halt = reset | ~enable;

    // bit_cnt_reg == 0 marks a load edge. A halt presets the counter to 0, so
    // the first edge after a halt loads a fresh byte. A partial byte is never
    // resumed.
    logic load_edge;
    assign load_edge = (bit_cnt_reg == 3'd0);

    // -------------------------------------------------------------------------
    // Control state machine, bit counter and registered status outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_8f) begin
        if (halt) begin
            state_reg     <= SYNC;
            bit_cnt_reg   <= 3'd0;
            comma_cnt_reg <= '0;
            ready_reg     <= 1'b0;
            active_reg    <= 1'b0;
        end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            // When bit_cnt_reg is 7 the next edge is a load edge. Ready is
            // therefore high for exactly the cycle before that load edge.
            ready_reg   <= (state_reg == ACTIVE) && (bit_cnt_reg == 3'd7);
            if (load_edge && (state_reg == SYNC)) begin
                if (comma_cnt_reg == LAST_COMMA) begin
                    state_reg     <= ACTIVE;
                    active_reg    <= 1'b1;
                    comma_cnt_reg <= '0;
                end else begin
                    comma_cnt_reg <= comma_cnt_reg + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane serializers. Both lanes share the load timing but choose their
    // bytes independently.
    // -------------------------------------------------------------------------
    logic [7:0] lane_data [2];
    logic [1:0] lane_valid;
    logic [1:0] lane_out;

    assign lane_data[0] = data_in_0;
    assign lane_data[1] = data_in_1;
    assign lane_valid   = {valid_in_1, valid_in_0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] load_byte;
            logic [6:0] shift_reg;
            logic       out_reg;

            // Data is only accepted once alignment is complete. The load edge
            // that finishes SYNC still sends a comma because state_reg is
            // still SYNC on that edge. A valid byte equal to COMMA is sent
            // unchanged.
            assign load_byte = ((state_reg == ACTIVE) && lane_valid[gi])
                               ? lane_data[gi] : COMMA;

            // The MSB goes straight to the output on the load edge. The other
            // seven bits wait in shift_reg, so the first bit appears in the
            // cycle right after the load edge.
            always_ff @(posedge clk_8f) begin
                if (halt) begin
                    out_reg   <= 1'b0;
                    shift_reg <= 7'd0;
                end else if (load_edge) begin
                    out_reg   <= load_byte[7];
                    shift_reg <= load_byte[6:0];
                end else begin
                    out_reg   <= shift_reg[6];
                    shift_reg <= {shift_reg[5:0], 1'b0};
                end
            end

            assign lane_out[gi] = out_reg;
        end
    endgenerate

    assign out_0  = lane_out[0];
    assign out_1  = lane_out[1];
    assign ready  = ready_reg;
    assign active = active_reg;

endmodule

// File: tb/tb_phy_tx.sv
module tb_phy_tx;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] data_in_0;
    logic       valid_in_0;
    logic [7:0] data_in_1;
    logic       valid_in_1;
    logic       out_0;
    logic       out_1;
    logic       ready;
    logic       active;

    int checks = 0;
    int passes = 0;

    phy_tx #(.COMMA(8'hBC), .SYNC_COUNT(4)) dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .enable     (enable),
        .data_in_0  (data_in_0),
        .valid_in_0 (valid_in_0),
        .data_in_1  (data_in_1),
        .valid_in_1 (valid_in_1),
        .out_0      (out_0),
        .out_1      (out_1),
        .ready      (ready),
        .active     (active)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct packed {
        logic [7:0] d0;
        logic       v0;
        logic [7:0] d1;
        logic       v1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Call this at a negedge where the next posedge is the first load edge
    // (cycle 0). It checks 32 cycles of commas, active rising at cycle 24 and
    // the first ready pulse at cycle 31.
    task automatic check_sync(input string tag);
        logic [7:0] cm;
        cm = 8'hBC;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk_8f);
            chk({tag, " sync out_0"}, 32'(out_0), 32'(cm[7 - (c % 8)]));
            chk({tag, " sync out_1"}, 32'(out_1), 32'(cm[7 - (c % 8)]));
            chk({tag, " sync active"}, 32'(active), 32'(c >= 24));
            chk({tag, " sync ready"}, 32'(ready), 32'(c == 31));
        end
        $display("%s: sync sequence checked, active=%0b ready=%0b", tag, active, ready);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk_8f);
            n++;
        end
        if (!ready) begin
            checks++;
            $display("FAIL %s ready timeout actual=0 required=1", tag);
        end
    endtask

    // Present one byte pair with ready, then capture the 8 bits of each lane.
    // After the load edge the inputs are changed to garbage, which the DUT
    // must ignore.
    task automatic send(input vec_t v, input string tag);
        logic [7:0] got0, got1;
        wait_ready(tag);
        data_in_0 = v.d0; valid_in_0 = v.v0;
        data_in_1 = v.d1; valid_in_1 = v.v1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_8f);
            got0[7 - i] = out_0;
            got1[7 - i] = out_1;
            if (i == 0) begin
                data_in_0 = ~v.d0; valid_in_0 = ~v.v0;
                data_in_1 = ~v.d1; valid_in_1 = ~v.v1;
            end
        end
        chk({tag, " out_0 byte"}, 32'(got0), 32'(v.e0));
        chk({tag, " out_1 byte"}, 32'(got1), 32'(v.e1));
        $display("%s: in0=%02h/%0b in1=%02h/%0b -> out0=%02h out1=%02h (exp %02h %02h)",
                 tag, v.d0, v.v0, v.d1, v.v1, got0, got1, v.e0, v.e1);
    endtask

    initial begin
        //          d0     v0    d1     v1    e0     e1
        vecs[0] = {8'h99, 1'b1, 8'h11, 1'b1, 8'h99, 8'h11};
        vecs[1] = {8'h88, 1'b1, 8'h5A, 1'b0, 8'h88, 8'hBC};
        vecs[2] = {8'hEE, 1'b1, 8'h00, 1'b0, 8'hEE, 8'hBC};
        vecs[3] = {8'hDD, 1'b1, 8'h00, 1'b0, 8'hDD, 8'hBC};
        vecs[4] = {8'hAA, 1'b1, 8'h00, 1'b0, 8'hAA, 8'hBC};
        vecs[5] = {8'hBC, 1'b1, 8'h3C, 1'b1, 8'hBC, 8'h3C};
        vecs[6] = {8'h00, 1'b0, 8'hFF, 1'b1, 8'hBC, 8'hFF};
        vecs[7] = {8'h00, 1'b1, 8'h81, 1'b1, 8'h00, 8'h81};

        reset = 1'b1; enable = 1'b1;
        data_in_0 = 8'h00; valid_in_0 = 1'b0;
        data_in_1 = 8'h00; valid_in_1 = 1'b0;

        // Reset is held for 8 cycles. All outputs must stay low.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_8f);
            chk("reset out_0", 32'(out_0), 32'd0);
            chk("reset out_1", 32'(out_1), 32'd0);
            chk("reset ready", 32'(ready), 32'd0);
            chk("reset active", 32'(active), 32'd0);
        end
        $display("reset: outputs low for 8 cycles");
        reset = 1'b0;
        check_sync("power-up");

        // The vectors run contiguously, so 0xEE/0xDD/0xAA go out back to back.
        for (int i = 0; i < 8; i++) send(vecs[i], $sformatf("vec%0d", i));

        // Reset for one cycle, applied after the 3rd bit of a data byte.
        // Commas are sent during resync even with valid held high.
        wait_ready("midreset");
        data_in_0 = 8'hE0; valid_in_0 = 1'b1;
        data_in_1 = 8'hE0; valid_in_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_8f);
            chk("midreset bit out_0", 32'(out_0), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk_8f);
        chk("midreset out_0", 32'(out_0), 32'd0);
        chk("midreset out_1", 32'(out_1), 32'd0);
        chk("midreset ready", 32'(ready), 32'd0);
        chk("midreset active", 32'(active), 32'd0);
        $display("midreset: byte aborted, out0=%0b active=%0b", out_0, active);
        reset = 1'b0;
        data_in_0 = 8'h00; data_in_1 = 8'h00;
        check_sync("after-reset");
        send(vecs[0], "post-reset");

        // Drop enable for 10 cycles while ACTIVE.
        wait_ready("endrop");
        @(negedge clk_8f);
        @(negedge clk_8f);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_8f);
            chk("disabled out_0", 32'(out_0), 32'd0);
            chk("disabled out_1", 32'(out_1), 32'd0);
            chk("disabled active", 32'(active), 32'd0);
            chk("disabled ready", 32'(ready), 32'd0);
        end
        $display("disable: outputs low for 10 cycles");
        enable = 1'b1;
        check_sync("re-enable");
        send(vecs[5], "post-enable");
        send(vecs[1], "post-enable2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phy_tx.md
PHY_TX -- requirements
Module: phy_tx

Interface
REQ-001 Parameter COMMA, default 8'hBC: idle/alignment byte sent on a lane that has no valid data.
REQ-002 Parameter SYNC_COUNT, default 4: number of COMMA bytes sent on both lanes after reset or enable before data is accepted.
REQ-003 clk_8f  input  1  bit clock; the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  transmitter enable.
REQ-006 data_in_0  input  8  lane 0 parallel byte.
REQ-007 valid_in_0  input  1  data_in_0 qualifier.
REQ-008 data_in_1  input  8  lane 1 parallel byte.
REQ-009 valid_in_1  input  1  data_in_1 qualifier.
REQ-010 out_0  output  1  lane 0 serial bit, registered.
REQ-011 out_1  output  1  lane 1 serial bit, registered.
REQ-012 ready  output  1  registered; high for exactly one cycle before each load edge in ACTIVE.
REQ-013 active  output  1  registered; high while state is ACTIVE.

Function
REQ-014 The block SHALL contain a 3-bit bit counter; every 8th rising edge is a "load edge", and the first load edge is the first edge with reset=0 and enable=1.
REQ-015 On a load edge each lane SHALL capture one byte and drive its bit 7 on out_x; the next 7 edges SHALL drive bits 6..0, MSB first, with no gap between bytes.
REQ-016 The state machine SHALL have two states: SYNC and ACTIVE.
REQ-017 In SYNC, every load edge SHALL load COMMA on both lanes regardless of valid_in_x, and a comma counter SHALL increment.
REQ-018 SYNC SHALL go to ACTIVE on the load edge that loads the SYNC_COUNT-th comma.
REQ-019 ready SHALL be high only in the cycle preceding a load edge while the state is ACTIVE.
REQ-020 In ACTIVE, on each load edge, lane x SHALL load data_in_x if valid_in_x=1, else COMMA; the two lanes are independent.
REQ-021 data_in_x and valid_in_x SHALL be sampled only on load edges; values at other edges are ignored.
REQ-022 A valid byte equal to COMMA SHALL be sent unchanged.
REQ-023 Latency: a byte sampled on a load edge SHALL have its MSB on out_x in the cycle immediately after that edge.
REQ-024 enable=0, sampled on any edge, SHALL take effect on that edge and behave like reset: out_x=0, ready=0, active=0, state SYNC, comma counter cleared, bit counter set so the next enabled edge is a load edge.
REQ-025 Raising enable again SHALL restart the SYNC_COUNT comma sequence.
REQ-026 reset SHALL take priority over enable.
REQ-027 A reset or enable drop mid-byte SHALL abort the byte immediately; no partial byte is resumed.

Reset
REQ-028 While reset=1 on an edge: out_0=0, out_1=0, ready=0, active=0, state SYNC, comma counter 0, bit counter preset so the first edge with reset=0 is a load edge.

Verification
REQ-029 Reset held 8 cycles, then released with enable=1 and valid_in_0/1=0 -> out_x=0 during reset; both lanes then send 10111100 continuously; active rises at cycle 24 (first load edge = cycle 0); ready first high at cycle 31.
REQ-030 In ACTIVE, lane0=0x99/valid, lane1=0x11/valid presented with ready -> out_0 = 10011001 and out_1 = 00010001 on the 8 cycles after the load edge.
REQ-031 Lane0=0x88/valid, lane1 valid=0 -> out_0 = 10001000 and out_1 = 10111100 (COMMA) on the same 8 cycles.
REQ-032 Back-to-back valid 0xEE, 0xDD, 0xAA on lane 0 across three consecutive ready pulses -> 24 contiguous bits 11101110 11011101 10101010 with no gap.
REQ-033 reset=1 for one cycle after the 3rd bit of a data byte -> out_x=0 on that edge, ready=0, active=0; after release, 4 commas precede the next ready.
REQ-034 enable=0 for 10 cycles in ACTIVE -> out_x=0 and active=0 throughout; on re-enable, SYNC_COUNT commas are sent, then ready resumes.
